// File: rtl/spram256ka.sv
// 16384 x 16 single-port SRAM with per-nibble write masks and standby/sleep/power-off controls.
// Read data is registered. A per-word valid bit makes never-written or powered-off words read as zero.
module spram256ka (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [13:0] ADDRESS,
   input  logic [15:0] DATAIN,
   input  logic [3:0]  MASKWREN,
   input  logic        WREN,
   input  logic        CHIPSELECT,
   input  logic        STANDBY,
   input  logic        SLEEP,
   input  logic        POWEROFF,
   output logic [15:0] DATAOUT
);

   localparam int DEPTH = 16384;

   logic             access_en;
   logic             wr_en;
   logic             rd_en;
   logic             word_valid;
   logic [DEPTH-1:0] valid_q;
   logic [15:0]      rd_data;
   logic             zero_q;
   logic             zero_d;

   assign access_en  = !RESET && POWEROFF && !SLEEP && !STANDBY && CHIPSELECT;
   assign wr_en      = access_en && WREN;
   assign rd_en      = access_en && !WREN;
   assign word_valid = valid_q[ADDRESS];

   // Valid bits rely on the all-zero flop state at configuration; RESET leaves them alone.
   always_ff @(posedge CLOCK) begin
      if (!POWEROFF) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[ADDRESS] <= 1'b1;
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_nib
         logic [3:0] mem_q [DEPTH];
         logic [3:0] rd_nib_q;
         logic       nib_we;

         // First write to an invalid word zero-fills the unmasked nibbles so stale data never reappears.
         assign nib_we = wr_en && (MASKWREN[gi] || !word_valid);

         always_ff @(posedge CLOCK) begin
            if (nib_we) begin
               mem_q[ADDRESS] <= MASKWREN[gi] ? DATAIN[4*gi+3 -: 4] : 4'h0;
            end
            if (rd_en) begin
               rd_nib_q <= mem_q[ADDRESS];
            end
         end

         assign rd_data[4*gi+3 -: 4] = rd_nib_q;
      end
   endgenerate

   always_comb begin
      zero_d = zero_q;
      if (!POWEROFF || SLEEP) begin
         zero_d = 1'b1;
      end else if (rd_en) begin
         zero_d = !word_valid;
      end
   end

   // Output blanking flag: async reset forces DATAOUT to zero without a clock.
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         zero_q <= 1'b1;
      end else begin
         zero_q <= zero_d;
      end
   end

   assign DATAOUT = zero_q ? 16'h0000 : rd_data;

endmodule

// File: tb/tb_spram256ka.sv
// Self-checking bench for spram256ka: directed scenarios plus a randomized run
// against a word-level reference model of the RAM contents.
module tb_spram256ka;

   logic        clk = 1'b0;
   logic        rst, cs, we, stb, slp, pwr;
   logic [13:0] addr;
   logic [15:0] din;
   logic [3:0]  mask;
   logic [15:0] dout;

   int checks   = 0;
   int failures = 0;

   // Reference model: what each word reads as, and what DATAOUT should show.
   logic [15:0] ref_mem [16384];
   logic [15:0] exp_dout;

   spram256ka dut (
      .CLOCK      (clk),
      .RESET      (rst),
      .ADDRESS    (addr),
      .DATAIN     (din),
      .MASKWREN   (mask),
      .WREN       (we),
      .CHIPSELECT (cs),
      .STANDBY    (stb),
      .SLEEP      (slp),
      .POWEROFF   (pwr),
      .DATAOUT    (dout)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic c, input logic w, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] m);
      cs = c; we = w; addr = a; din = d; mask = m;
   endtask

   // Apply the mode rules to the model for the coming edge, then clock.
   task automatic tick();
      logic [15:0] bm;
      if (!pwr) begin
         for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
      end
      if (rst || !pwr || slp) begin
         exp_dout = 16'h0000;
      end else if (stb || !cs) begin
         exp_dout = exp_dout;
      end else if (we) begin
         for (int i = 0; i < 16; i++) bm[i] = mask[i/4];
         ref_mem[addr] = (ref_mem[addr] & ~bm) | (din & bm);
      end else begin
         exp_dout = ref_mem[addr];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
      drive(1'b1, 1'b1, a, d, m);
      tick();
   endtask

   task automatic rd(input logic [13:0] a);
      drive(1'b1, 1'b0, a, 16'h0000, 4'h0);
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
      tick(); tick();
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL reset_dout got=%h exp=0000", dout); end
      rst = 1'b0;
      rd(14'h0000);
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL reset_read0 got=%h exp=0000", dout); end
      wr(14'h0050, 16'hBEEF, 4'hF);
      rd(14'h0050);
      checks++;
      if (dout !== 16'hBEEF) begin failures++; $display("FAIL pre_reset_read got=%h exp=beef", dout); end
      #2 rst = 1'b1;
      exp_dout = 16'h0000;
      #1;
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL async_reset got=%h exp=0000", dout); end
      #1 rst = 1'b0;
      drive(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
      tick();
      $display("test_reset done");
   endtask

   task automatic test_basic();
      wr(14'h3FFF, 16'hA5C3, 4'hF);
      rd(14'h3FFF);
      checks++;
      if (dout !== 16'hA5C3) begin failures++; $display("FAIL basic_read got=%h exp=a5c3", dout); end
      rd(14'h0000);
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL unwritten_read got=%h exp=0000", dout); end
      $display("test_basic done");
   endtask

   task automatic test_mask();
      wr(14'h0010, 16'h1234, 4'b1111);
      wr(14'h0010, 16'hFFFF, 4'b0011);
      rd(14'h0010);
      checks++;
      if (dout !== 16'h12FF) begin failures++; $display("FAIL mask_low got=%h exp=12ff", dout); end
      wr(14'h0010, 16'h0000, 4'b1100);
      rd(14'h0010);
      checks++;
      if (dout !== 16'h00FF) begin failures++; $display("FAIL mask_high got=%h exp=00ff", dout); end
      wr(14'h0200, 16'hABCD, 4'b0000);
      rd(14'h0200);
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL mask_none got=%h exp=0000", dout); end
      $display("test_mask done");
   endtask

   task automatic test_cs();
      wr(14'h0020, 16'h5555, 4'hF);
      rd(14'h0020);
      drive(1'b0, 1'b1, 14'h0020, 16'hDEAD, 4'hF);
      tick();
      checks++;
      if (dout !== 16'h5555) begin failures++; $display("FAIL cs_hold got=%h exp=5555", dout); end
      wr(14'h0021, 16'h9999, 4'hF);
      checks++;
      if (dout !== 16'h5555) begin failures++; $display("FAIL write_hold got=%h exp=5555", dout); end
      rd(14'h0020);
      checks++;
      if (dout !== 16'h5555) begin failures++; $display("FAIL cs_blocked_write got=%h exp=5555", dout); end
      $display("test_cs done");
   endtask

   task automatic test_power();
      wr(14'h0100, 16'h7777, 4'hF);
      rd(14'h0100);
      stb = 1'b1;
      rd(14'h0021);
      checks++;
      if (dout !== 16'h7777) begin failures++; $display("FAIL standby_hold got=%h exp=7777", dout); end
      stb = 1'b0; slp = 1'b1;
      rd(14'h0021);
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL sleep_zero got=%h exp=0000", dout); end
      wr(14'h0100, 16'h1234, 4'hF);
      slp = 1'b0;
      rd(14'h0100);
      checks++;
      if (dout !== 16'h7777) begin failures++; $display("FAIL sleep_wake_read got=%h exp=7777", dout); end
      pwr = 1'b0;
      drive(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
      tick();
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL poweroff_zero got=%h exp=0000", dout); end
      pwr = 1'b1;
      rd(14'h0100);
      checks++;
      if (dout !== 16'h0000) begin failures++; $display("FAIL poweroff_lost got=%h exp=0000", dout); end
      wr(14'h0100, 16'h00F0, 4'b0010);
      rd(14'h0100);
      checks++;
      if (dout !== 16'h00F0) begin failures++; $display("FAIL poweroff_partial got=%h exp=00f0", dout); end
      $display("test_power done");
   endtask

   task automatic test_back_to_back();
      logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      for (int i = 0; i < 4; i++) wr(14'(i + 1), vals[i], 4'hF);
      for (int i = 0; i < 4; i++) begin
         rd(14'(i + 1));
         checks++;
         if (dout !== vals[i]) begin
            failures++;
            $display("FAIL b2b_read%0d got=%h exp=%h", i, dout, vals[i]);
         end
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         stb = ($urandom_range(0, 9) == 0);
         slp = ($urandom_range(0, 11) == 0);
         pwr = ($urandom_range(0, 79) != 0);
         drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
               ($urandom_range(0, 7) == 0) ? 14'($urandom) : 14'($urandom_range(0, 15)),
               16'($urandom), 4'($urandom));
         tick();
         checks++;
         if (dout !== exp_dout) begin
            failures++;
            $display("FAIL random_%0d got=%h exp=%h", n, dout, exp_dout);
         end
      end
      stb = 1'b0; slp = 1'b0; pwr = 1'b1;
      $display("test_random done");
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
      exp_dout = 16'h0000;
      rst = 1'b1; stb = 1'b0; slp = 1'b0; pwr = 1'b1;
      drive(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
      test_reset();
      test_basic();
      test_mask();
      test_cs();
      test_power();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
